// File: rtl/charlieplex_led_driver.sv
// Charlieplexed LED scanner: walks NPINS*(NPINS-1) LED slots, driving one anode/cathode pair
// per slot after a short all-tristate blanking interval. Each LED's state can come from the live
// request, a sticky capture, or a software override, optionally gated by a shared blink phase.
module charlieplex_led_driver #(
    parameter int unsigned NPINS          = 4,
    parameter int unsigned DWELL_CYCLES   = 64,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned BLINK_DIV_LOG2 = 22,
    localparam int unsigned NLEDS         = NPINS * (NPINS - 1),
    localparam int unsigned SW            = $clog2(NLEDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NLEDS-1:0] led_i,
    input  logic [NLEDS-1:0] ovr_en_i,
    input  logic [NLEDS-1:0] ovr_val_i,
    input  logic [NLEDS-1:0] sticky_en_i,
    input  logic [NLEDS-1:0] sticky_clr_i,
    input  logic [NLEDS-1:0] blink_en_i,
    output logic [NPINS-1:0] pin_o,
    output logic [NPINS-1:0] pin_oen_o,
    output logic [NLEDS-1:0] led_state_o,
    output logic [SW-1:0]    slot_o
);

    localparam int unsigned      DW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned      BW        = BLINK_DIV_LOG2;
    localparam logic [DW-1:0]    DwellLast = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]    BlankEnd  = DW'(BLANK_CYCLES);
    localparam logic [SW-1:0]    SlotLast  = SW'(NLEDS - 1);

    logic [DW-1:0]    dwell_q, dwell_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [NLEDS-1:0] sticky_q, sticky_d;
    logic [NLEDS-1:0] led_state_q, led_state_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [NPINS-1:0] pin_q, pin_d;
    logic [NPINS-1:0] pin_oen_q, pin_oen_d;

    logic [NLEDS-1:0] src;
    logic [NLEDS-1:0] ovr_mux;
    logic [NLEDS-1:0] eff;
    logic [NPINS-1:0] anode_mask;
    logic [NPINS-1:0] cathode_mask;
    int unsigned      slot_idx;
    int unsigned      a_idx;
    int unsigned      j_idx;
    int unsigned      c_idx;

    // Effective LED state: source select, then override, then blink gate (blink also hits overrides)
    always_comb begin
        src     = (sticky_en_i & sticky_q) | (~sticky_en_i & led_i);
        ovr_mux = (ovr_en_i & ovr_val_i) | (~ovr_en_i & src);
        eff     = ovr_mux & (~blink_en_i | {NLEDS{phase_q}});
    end

    // Slot to anode/cathode: the cathode index skips over the anode pin
    always_comb begin
        slot_idx     = 32'(slot_q);
        a_idx        = slot_idx / (NPINS - 1);
        j_idx        = slot_idx % (NPINS - 1);
        c_idx        = (j_idx < a_idx) ? j_idx : j_idx + 1;
        anode_mask   = NPINS'(1'b1) << a_idx;
        cathode_mask = NPINS'(1'b1) << c_idx;
    end

    // Next state: scan counters, sticky capture, blink prescaler and registered pin drive
    always_comb begin
        dwell_d     = dwell_q + DW'(1);
        slot_d      = slot_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        sticky_d    = (sticky_q & ~sticky_clr_i) | led_i;
        led_state_d = eff;
        pin_oen_d   = '1;
        pin_d       = '0;

        if (dwell_q == DwellLast) begin
            dwell_d = '0;
            slot_d  = (slot_q == SlotLast) ? '0 : slot_q + SW'(1);
        end

        // Counter wraps naturally; toggle on the last count of the period
        if (blink_cnt_q == {BW{1'b1}}) begin
            phase_d = ~phase_q;
        end

        // Blank at the head of every slot so the previous pair fully releases first
        if ((dwell_q >= BlankEnd) && eff[slot_q]) begin
            pin_oen_d = ~(anode_mask | cathode_mask);
            pin_d     = anode_mask;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_q     <= '0;
            slot_q      <= '0;
            sticky_q    <= '0;
            led_state_q <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pin_q       <= '0;
            pin_oen_q   <= '1;
        end else begin
            dwell_q     <= dwell_d;
            slot_q      <= slot_d;
            sticky_q    <= sticky_d;
            led_state_q <= led_state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pin_q       <= pin_d;
            pin_oen_q   <= pin_oen_d;
        end
    end

    assign pin_o       = pin_q;
    assign pin_oen_o   = pin_oen_q;
    assign led_state_o = led_state_q;
    assign slot_o      = slot_q;

endmodule

// File: tb/tb_charlieplex_led_driver.sv
// Directed bench for charlieplex_led_driver with a cycle-level reference model feeding a
// scoreboard queue; expected outputs are pushed before each clock edge and popped after it.
module tb_charlieplex_led_driver;

    localparam int NPINS = 4;
    localparam int NLEDS = 12;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int BLINK = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NLEDS-1:0] led, ovr_en, ovr_val, st_en, st_clr, bl_en;
    logic [NPINS-1:0] pin, oen;
    logic [NLEDS-1:0] led_state;
    logic [3:0]       slot;

    charlieplex_led_driver #(
        .NPINS          (NPINS),
        .DWELL_CYCLES   (DWELL),
        .BLANK_CYCLES   (BLANK),
        .BLINK_DIV_LOG2 (BLINK)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .led_i        (led),
        .ovr_en_i     (ovr_en),
        .ovr_val_i    (ovr_val),
        .sticky_en_i  (st_en),
        .sticky_clr_i (st_clr),
        .blink_en_i   (bl_en),
        .pin_o        (pin),
        .pin_oen_o    (oen),
        .led_state_o  (led_state),
        .slot_o       (slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [11:0] ls;
        logic [3:0]  oen;
        logic [3:0]  pin;
        logic [3:0]  slot;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Anode/cathode per LED for a 4-pin array, written out by hand
    int an_tab [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int ca_tab [12] = '{1, 2, 3, 0, 2, 3, 0, 1, 3, 0, 1, 2};

    // Reference model state (mirrors what the DUT holds after the most recent edge)
    int          m_dwell = 0;
    int          m_slot  = 0;
    int          m_cnt   = 0;
    bit          m_phase = 1'b0;
    logic [11:0] m_sticky = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Predict the outputs after the coming edge and advance the model
    task automatic predict(input string tag);
        exp_t        e;
        logic [11:0] eff;
        logic        v;
        for (int k = 0; k < NLEDS; k++) begin
            if (ovr_en[k]) v = ovr_val[k];
            else if (st_en[k]) v = m_sticky[k];
            else v = led[k];
            if (bl_en[k] && !m_phase) v = 1'b0;
            eff[k] = v;
        end
        e.tag = tag;
        if (rst) begin
            e.ls = '0; e.oen = 4'hf; e.pin = 4'h0;
            m_dwell = 0; m_slot = 0; m_cnt = 0; m_phase = 1'b0; m_sticky = '0;
        end else begin
            e.ls = eff;
            if (m_dwell < BLANK || !eff[m_slot]) begin
                e.oen = 4'hf; e.pin = 4'h0;
            end else begin
                e.oen = 4'hf & ~((4'h1 << an_tab[m_slot]) | (4'h1 << ca_tab[m_slot]));
                e.pin = 4'h1 << an_tab[m_slot];
            end
            for (int k = 0; k < NLEDS; k++) begin
                if (led[k]) m_sticky[k] = 1'b1;
                else if (st_clr[k]) m_sticky[k] = 1'b0;
            end
            if (m_cnt == (1 << BLINK) - 1) begin
                m_cnt = 0; m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
            if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                m_slot  = (m_slot == NLEDS - 1) ? 0 : m_slot + 1;
            end else begin
                m_dwell++;
            end
        end
        e.slot = 4'(m_slot);
        sb.push_back(e);
    endtask

    // One clock: push expectation, clock, pop and compare, plus pin safety invariants
    task automatic step(input string tag);
        exp_t e;
        int   nz;
        int   lvl_sum;
        predict(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_led_state"}, 32'(led_state), 32'(e.ls));
        chk({e.tag, "_oen"},       32'(oen),       32'(e.oen));
        chk({e.tag, "_pin"},       32'(pin),       32'(e.pin));
        chk({e.tag, "_slot"},      32'(slot),      32'(e.slot));
        nz = 0;
        lvl_sum = 0;
        for (int p = 0; p < NPINS; p++) begin
            if (oen[p] == 1'b0) begin
                nz++;
                lvl_sum += int'(pin[p]);
            end
        end
        chk({e.tag, "_max_driven"}, 32'(nz <= 2), 32'(1));
        if (nz == 2) chk({e.tag, "_opposite_levels"}, 32'(lvl_sum), 32'(1));
    endtask

    initial begin
        bit reached;
        rst = 1'b1;
        led = '0; ovr_en = '0; ovr_val = '0; st_en = '0; st_clr = '0; bl_en = '0;
        step("reset");
        step("reset");
        rst = 1'b0;

        // Mapping: one LED at a time over a full scan each
        for (int k = 0; k < NLEDS; k++) begin
            led = 12'h001 << k;
            repeat (NLEDS * DWELL) step("map");
        end

        // All LEDs on: blanking at slot heads and full slot sequence with wrap
        led = '1;
        repeat (NLEDS * DWELL + 4) step("blank");

        // Override on, then override forcing dark against a live request
        led = '0; ovr_en = 12'h020; ovr_val = 12'h020;
        repeat (NLEDS * DWELL) step("ovr_on");
        chk("ovr_on_bit5", 32'(led_state[5]), 32'(1));
        ovr_val = '0; led = 12'h020;
        repeat (NLEDS * DWELL) step("ovr_off");
        chk("ovr_off_bit5", 32'(led_state[5]), 32'(0));

        // Sticky capture, clear, and set-wins-over-clear
        ovr_en = '0; led = '0;
        rst = 1'b1; step("st_reset"); rst = 1'b0;
        st_en = 12'h004;
        led = 12'h004; step("st_pulse");
        led = '0; step("st_hold"); step("st_hold");
        chk("sticky_held", 32'(led_state[2]), 32'(1));
        st_clr = 12'h004; step("st_clr");
        st_clr = '0; step("st_clr_after");
        chk("sticky_cleared", 32'(led_state[2]), 32'(0));
        led = 12'h004; st_clr = 12'h004; step("st_both");
        led = '0; st_clr = '0; step("st_both_after"); step("st_both_after");
        chk("sticky_set_wins", 32'(led_state[2]), 32'(1));

        // Blink phase from reset: dark for 8 cycles, lit for 8, alternating
        st_en = '0; bl_en = 12'h001; led = 12'h001;
        rst = 1'b1; step("bl_reset"); rst = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            step("blink");
            chk("blink_phase", 32'(led_state[0]), 32'(((n - 1) / 8) % 2));
        end

        // Reset mid-scan at slot 7, dwell 2 with sticky set and blink running
        st_en = 12'h004; led = 12'h005; step("mid_setup");
        led = 12'h001;
        for (int i = 0; i < 100 && !(m_slot == 7 && m_dwell == 2); i++) step("seek");
        reached = (m_slot == 7 && m_dwell == 2);
        chk("seek_slot7_dwell2", 32'(reached), 32'(1));
        rst = 1'b1; step("mid_reset"); rst = 1'b0;
        chk("mid_reset_slot", 32'(slot), 32'(0));
        chk("mid_reset_oen", 32'(oen), 32'(4'hf));
        led = '0; step("mid_after");
        chk("mid_sticky_cleared", 32'(led_state[2]), 32'(0));
        chk("mid_phase_zero", 32'(led_state[0]), 32'(0));
        repeat (8) step("mid_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/charlieplex_led_driver.md
Name: charlieplex_led_driver

Overview:
Parametrised charlieplexed LED scanner for the SURF-family ID/control blocks; generalises the fixed 4-pin/12-LED driver to NPINS pins.
- LED count is NPINS*(NPINS-1).
- Adds per-LED software override, sticky capture with clear, per-LED blink, and an anti-ghosting blanking interval at each slot change.
- Sits between the control-register block (override/blink/sticky masks) and the bidirectional LED pins; pin tristate is applied outside the block.

Parameters:
- NPINS, 4, number of charlieplex pins; must be >= 2. Localparam NLEDS = NPINS*(NPINS-1).
- DWELL_CYCLES, 64, clk_i cycles per LED slot; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 2, cycles at the start of each slot with all pins tristated.
- BLINK_DIV_LOG2, 22, blink phase toggles every 2^BLINK_DIV_LOG2 cycles.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, synchronous active-high reset.
- led_i, input, NLEDS, internal LED requests (level).
- ovr_en_i, input, NLEDS, per-LED override enable.
- ovr_val_i, input, NLEDS, override value used when ovr_en_i[k]=1.
- sticky_en_i, input, NLEDS, per-LED sticky-capture mode.
- sticky_clr_i, input, NLEDS, per-LED clear of sticky capture; single-cycle strobe.
- blink_en_i, input, NLEDS, gate LED with blink phase.
- pin_o, output, NPINS, pin drive value.
- pin_oen_o, output, NPINS, 1 = tristate, 0 = drive pin_o.
- led_state_o, output, NLEDS, effective per-LED state (register readback).
- slot_o, output, clog2(NLEDS), currently scanned LED index.

Behaviour:
Clock and reset
- One clock (clk_i). Reset is synchronous and active-high on rst_i.
- Reset values: pin_oen_o all 1, pin_o 0, led_state_o 0, slot_o 0, dwell counter 0, sticky register 0, blink phase 0.

Scan counters
- dwell counts 0..DWELL_CYCLES-1, then wraps to 0.
- On a dwell wrap, slot advances; slot NLEDS-1 wraps to 0.

Sticky capture
- sticky[k] <= (sticky[k] & ~sticky_clr_i[k]) | led_i[k].
- When set and clear coincide, set wins.
- Sticky updates continuously, regardless of sticky_en_i.

Blink
- Prescaler counts 2^BLINK_DIV_LOG2 cycles, then toggles the phase.
- Phase 0 = dark, so blinking LEDs start dark after reset.

Effective state, per LED k, as a combinational chain
- src = sticky_en_i[k] ? sticky[k] : led_i[k].
- v = ovr_en_i[k] ? ovr_val_i[k] : src.
- eff[k] = v & (~blink_en_i[k] | phase). Blink applies to override values too.
- led_state_o <= eff, registered one cycle.

Pin mapping for LED k
- a = k / (NPINS-1); j = k % (NPINS-1); c = (j < a) ? j : j+1.
- Anode pin a is driven 1; cathode pin c is driven 0; all other pins are tristate.
- NPINS=4: k=0 gives a=0,c=1; k=11 gives a=3,c=2.

Outputs (registered, latency 1)
- If dwell < BLANK_CYCLES, or eff[slot]=0: pin_oen_o all 1 and pin_o 0.
- Otherwise: pin_oen_o has 0 only at bits a and c; pin_o has 1 only at bit a.
- eff[slot] is sampled every cycle, so an LED change takes effect within the current slot, 1 cycle later.

Invariants
- Never more than two pins driven at once.
- Driven pins are never both at the same level.

Reset mid-scan
- The next cycle returns to the reset state and the scan restarts from slot 0, dwell 0, with a blanking interval first.

Test Plan:
Bench parameters: NPINS=4, DWELL_CYCLES=4, BLANK_CYCLES=1, BLINK_DIV_LOG2=3.
1. Mapping: led_i=12'h001 -> in slot 0, dwell 1..3 (observed 1 cycle later), pin_oen_o=4'b1100, pin_o=4'b0001. Repeat for each k: led_i=1<<k -> anode/cathode per formula (k=11: oen=4'b0011, pin_o=4'b1000). In other slots oen=4'b1111.
2. Blanking: led_i all ones -> oen=4'b1111 on the first output cycle of each slot; never more than 2 zero bits in oen; slot sequence 0..11,0.
3. Override: led_i=0, ovr_en_i[5]=1, ovr_val_i[5]=1 -> LED 5 lit (a=1,c=3, oen=4'b0101, pin_o=4'b0010). Then ovr_val_i[5]=0 with led_i[5]=1 -> LED 5 dark, led_state_o[5]=0.
4. Sticky: sticky_en_i[2]=1, single-cycle pulse on led_i[2] -> led_state_o[2] stays 1. sticky_clr_i[2] pulsed alone -> 0 next cycle. clr and led_i[2] in the same cycle -> remains 1.
5. Blink: blink_en_i[0]=1, led_i[0]=1 -> led_state_o[0] is 0 for cycles 1..8 after reset, 1 for the next 8, alternating.
6. Reset mid-scan: assert rst_i at slot 7, dwell 2 -> next cycle slot_o=0, oen=4'b1111, sticky cleared, blink phase 0.
